// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: memory-stage responder that splits each 32-bit
// load/store into two 16-bit halfword accesses on an asynchronous SRAM.
// ready is held low while an access is in flight; the pipeline freezes on it.
// Optional build macro SRAM_CTRL_STATS_EN adds rd_count/wr_count outputs that
// count completed reads and writes.
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_t             state_q;
  logic               op_wr_q;
  logic [SRAM_AW-2:0] word_q;
  logic [15:0]        wdata_hi_q;
  logic [CW-1:0]      cnt_q;

  // Byte offset from the SRAM window base; wraps modulo 2^32.
  logic [31:0] offset_d;
  assign offset_d = ALU_result - 32'(BASE_ADDR);

  // Byte-lane bits and address bits above the SRAM window are intentionally dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset_d[31:SRAM_AW+1], offset_d[1:0]};

  // Freeze the pipeline while a halfword phase runs or a new request is being taken.
  always_comb begin
    ready = 1'b1;
    if (state_q == LOW || state_q == HIGH)
      ready = 1'b0;
    else if (state_q == IDLE && (MEM_R_EN || MEM_W_EN))
      ready = 1'b0;
  end

  // Access sequencer: latch the command, run LOW then HIGH phases, one DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      cnt_q       <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
`ifdef SRAM_CTRL_STATS_EN
      rd_count    <= '0;
      wr_count    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (MEM_W_EN || MEM_R_EN) begin
            // A simultaneous read and write request is served as a write.
            op_wr_q     <= MEM_W_EN;
            word_q      <= offset_d[SRAM_AW:2];
            wdata_hi_q  <= ST_val[31:16];
            cnt_q       <= '0;
            state_q     <= LOW;
            sram_addr   <= {offset_d[SRAM_AW:2], 1'b0};
            sram_dq_out <= ST_val[15:0];
            sram_dq_oe  <= MEM_W_EN;
            sram_we_n   <= ~MEM_W_EN;
            sram_oe_n   <= MEM_W_EN;
          end
        end
        LOW: begin
          if (cnt_q == LAST) begin
            if (!op_wr_q)
              rdata[15:0] <= sram_dq_in;
            cnt_q       <= '0;
            state_q     <= HIGH;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= wdata_hi_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HIGH: begin
          if (cnt_q == LAST) begin
            if (!op_wr_q)
              rdata[31:16] <= sram_dq_in;
            cnt_q      <= '0;
            state_q    <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
`ifdef SRAM_CTRL_STATS_EN
            if (op_wr_q)
              wr_count <= wr_count + 32'd1;
            else
              rd_count <= rd_count + 32'd1;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // Any request present now belongs to the stage that advances on this edge.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench for mem_stage_sram_ctrl: directed literal scenarios followed by
// randomized request traffic, checked every cycle against a transaction-level
// model (access timeline + reference halfword memory).
module tb_mem_stage_sram_ctrl;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_en, w_en;
  logic [31:0]   alu, st;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0]   rd_count, wr_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .ALU_result(alu), .ST_val(st), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
`ifdef SRAM_CTRL_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device model and the bench's own reference contents.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [15:0] ref_mem  [0:(1<<AW)-1];

  assign sram_dq_in = (!sram_oe_n) ? sram_mem[sram_addr] : 16'hF00D;

  always @(posedge clk)
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Halfword address of half h for byte address a: ((a-BASE)/4)*2+h mod 2^AW.
  function automatic logic [AW-1:0] half_addr(input logic [31:0] a, input int h);
    logic [31:0] wd, ha;
    wd = (a - 32'(BASE)) >> 2;
    ha = wd * 32'd2 + 32'(h);
    return ha[AW-1:0];
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_active = 0, m_done = 0, m_wr = 0;
  int          m_k = 0;
  logic [31:0] m_a = '0, m_wdata = '0, exp_rdata = '0;
  logic [31:0] exp_rd_cnt = '0, exp_wr_cnt = '0;

  always @(negedge clk) begin
    int h;
    logic [AW-1:0] ha;
    logic [15:0] hv;
    chk("no_oe_conflict", {31'd0, (!sram_oe_n && sram_dq_oe)}, 32'd0);
    chk("we_needs_drive", {31'd0, (!sram_we_n && !sram_dq_oe)}, 32'd0);
    if (!rst) begin
      m_active = 0; m_done = 0; exp_rdata = '0;
      exp_rd_cnt = '0; exp_wr_cnt = '0;
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ready", {31'd0, ready}, {31'd0, !(r_en || w_en)});
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    end else begin
      chk("rdata", rdata, exp_rdata);
      if (m_active) begin
        m_k++;
        h  = (m_k - 1) / W;
        ha = half_addr(m_a, h);
        chk("busy_ready", {31'd0, ready}, 32'd0);
        chk("phase_addr", {14'd0, sram_addr}, {14'd0, ha});
        if (m_wr) begin
          hv = (h == 1) ? m_wdata[31:16] : m_wdata[15:0];
          chk("wr_dq_oe", {31'd0, sram_dq_oe}, 32'd1);
          chk("wr_we_n", {31'd0, sram_we_n}, 32'd0);
          chk("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
          chk("wr_dq_out", {16'd0, sram_dq_out}, {16'd0, hv});
          ref_mem[ha] = hv;
        end else begin
          chk("rd_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
          chk("rd_we_n", {31'd0, sram_we_n}, 32'd1);
          chk("rd_oe_n", {31'd0, sram_oe_n}, 32'd0);
          if ((m_k % W) == 0) begin
            if (h == 1) exp_rdata[31:16] = ref_mem[ha];
            else        exp_rdata[15:0]  = ref_mem[ha];
          end
        end
        if (m_k == 2 * W) begin
          m_active = 0;
          m_done   = 1;
          if (m_wr) exp_wr_cnt++;
          else      exp_rd_cnt++;
        end
      end else begin
        chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("idle_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        if (m_done) begin
          chk("done_ready", {31'd0, ready}, 32'd1);
          m_done = 0;
        end else begin
          chk("idle_ready", {31'd0, ready}, {31'd0, !(r_en || w_en)});
          if (r_en || w_en) begin
            m_active = 1; m_k = 0; m_wr = w_en; m_a = alu; m_wdata = st;
          end
        end
      end
    end
`ifdef SRAM_CTRL_STATS_EN
    chk("rd_count", rd_count, exp_rd_cnt);
    chk("wr_count", wr_count, exp_wr_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    r_en = r; w_en = w; alu = a; st = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = 16'(i) ^ 16'hA5A5;
      ref_mem[i]  = 16'(i) ^ 16'hA5A5;
    end
    rst = 1'b0;
    set_in(0, 0, 32'd0, 32'd0);
    repeat (3) next_cycle();
    rst = 1'b1;
    next_cycle();
    chk("lit_idle_ready", {31'd0, ready}, 32'd1);
    chk("lit_idle_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("lit_idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("lit_idle_rdata", rdata, 32'd0);

    // Write 0xDEADBEEF at 1032 -> halfwords 4 and 5.
    set_in(0, 1, 32'd1032, 32'hDEADBEEF);
    #1 chk("lit_wr_c0_ready", {31'd0, ready}, 32'd0);
    next_cycle();
    chk("lit_wr_c1_addr", {14'd0, sram_addr}, 32'd4);
    chk("lit_wr_c1_dq", {16'd0, sram_dq_out}, 32'h0000BEEF);
    chk("lit_wr_c1_we_n", {31'd0, sram_we_n}, 32'd0);
    next_cycle();
    chk("lit_wr_c2_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("lit_wr_c2_ready", {31'd0, ready}, 32'd0);
    next_cycle();
    chk("lit_wr_c3_addr", {14'd0, sram_addr}, 32'd5);
    chk("lit_wr_c3_dq", {16'd0, sram_dq_out}, 32'h0000DEAD);
    next_cycle();
    chk("lit_wr_c4_ready", {31'd0, ready}, 32'd0);
    next_cycle();
    chk("lit_wr_c5_ready", {31'd0, ready}, 32'd1);
    set_in(0, 0, 32'd0, 32'd0);
    next_cycle();

    // Read back 1032.
    set_in(1, 0, 32'd1032, 32'd0);
    repeat (5) next_cycle();
    chk("lit_rd_c5_rdata", rdata, 32'hDEADBEEF);
    chk("lit_rd_c5_ready", {31'd0, ready}, 32'd1);
    set_in(0, 0, 32'd0, 32'd0);
    next_cycle();
    chk("lit_rd_hold", rdata, 32'hDEADBEEF);

    // Both enables: a write to halfwords 0/1, rdata untouched.
    set_in(1, 1, 32'd1024, 32'h12345678);
    repeat (5) next_cycle();
    chk("lit_both_rdata", rdata, 32'hDEADBEEF);
    chk("lit_both_lo", {16'd0, sram_mem[0]}, 32'h00005678);
    chk("lit_both_hi", {16'd0, sram_mem[1]}, 32'h00001234);
    set_in(0, 0, 32'd0, 32'd0);
    next_cycle();

    // Back-to-back reads at 1024 then 1028; second request already present in DONE.
    set_in(1, 0, 32'd1024, 32'd0);
    repeat (5) next_cycle();
    chk("lit_b2b_done_ready", {31'd0, ready}, 32'd1);
    chk("lit_b2b_first", rdata, 32'h12345678);
    set_in(1, 0, 32'd1028, 32'd0);
    next_cycle();
    chk("lit_b2b_accept_ready", {31'd0, ready}, 32'd0);
    chk("lit_b2b_accept_oe_n", {31'd0, sram_oe_n}, 32'd1);
    next_cycle();
    chk("lit_b2b_addr", {14'd0, sram_addr}, 32'd2);
    chk("lit_b2b_oe_n", {31'd0, sram_oe_n}, 32'd0);
    repeat (4) next_cycle();
    chk("lit_b2b_second", rdata, 32'hA5A6A5A7);
    set_in(0, 0, 32'd0, 32'd0);
    next_cycle();

    // Reset pulsed during HIGH of a write.
    set_in(0, 1, 32'd1040, 32'hCAFEF00D);
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    chk("lit_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("lit_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("lit_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("lit_rst_ready_req", {31'd0, ready}, 32'd0);
    set_in(0, 0, 32'd0, 32'd0);
    #1 chk("lit_rst_ready_idle", {31'd0, ready}, 32'd1);
`ifdef SRAM_CTRL_STATS_EN
    chk("lit_rst_wr_count", wr_count, 32'd0);
`endif
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int kind, sel;
      logic [31:0] a;
      kind = $urandom_range(0, 11);
      sel  = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = 32'(BASE) + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      if (kind < 2) begin
        set_in(0, 0, $urandom(), $urandom());
        repeat ($urandom_range(1, 3)) next_cycle();
      end else if (kind == 2) begin
        set_in(sel != 1, sel == 1 || sel == 2, a, $urandom());
        repeat ($urandom_range(1, 2 * W)) next_cycle();
        rst = 1'b0;
        if ($urandom_range(0, 1) == 1) set_in(0, 0, 32'd0, 32'd0);
        next_cycle();
        rst = 1'b1;
      end else begin
        set_in(sel != 1, sel == 1 || sel == 2, a, $urandom());
        repeat (2 * W + 1) next_cycle();
        if ($urandom_range(0, 1) == 1)
          set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom(), $urandom());
        else
          set_in(0, 0, 32'd0, 32'd0);
        next_cycle();
      end
    end

    set_in(0, 0, 32'd0, 32'd0);
    repeat (3) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
